// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use hazard detector and forwarding scheduler for a
// 5-stage MIPS pipeline. Owns the destination-register mux select, tracks the
// selected destination through EX/MEM/WB, stalls ID on load-use conflicts and
// registers forwarding selects for the instruction entering EX.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   id_valid                 ID stage holds a real instruction
//   id_rs, id_rt, id_rd      register fields of the ID instruction
//   id_uses_rs, id_uses_rt   instruction reads rs / rt
//   id_regdst                1 = rd is destination, 0 = rt
//   id_regwrite, id_memread  writes the register file / is a load
//   flush                    kill the ID instruction this cycle
//   dst_sel                  destination mux select (combinational)
//   stall                    freeze PC and IF/ID, bubble into ID/EX (combinational)
//   fwd_a, fwd_b             registered forwarding selects (00 RF, 10 EX/MEM, 01 MEM/WB)
//   ex_dst, mem_dst, wb_dst  tracked destinations, 0 = none
//   stall_count              saturating stall-cycle counter
module hazard_scoreboard #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regdst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             dst_sel,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [4:0]       ex_dst,
    output logic [4:0]       mem_dst,
    output logic [4:0]       wb_dst,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned REG_W = 5;
    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [1:0]  FWD_EXM = 2'b10;
    localparam logic [1:0]  FWD_MWB = 2'b01;

    logic             ex_valid;
    logic             ex_load;
    logic             mem_valid;
    logic [REG_W-1:0] id_dst;
    logic             id_dst_valid;
    logic             rs_ex;
    logic             rt_ex;
    logic             rs_mem;
    logic             rt_mem;
    logic             bubble;
    logic [1:0]       fwd_a_next;
    logic [1:0]       fwd_b_next;

    // Destination selection and source-vs-slot match detection.
    always_comb begin
        dst_sel      = id_regdst;
        id_dst       = id_regdst ? id_rd : id_rt;
        id_dst_valid = id_regwrite && (id_dst != '0);
        rs_ex        = id_uses_rs && ex_valid  && (id_rs == ex_dst);
        rt_ex        = id_uses_rt && ex_valid  && (id_rt == ex_dst);
        rs_mem       = id_uses_rs && mem_valid && (id_rs == mem_dst);
        rt_mem       = id_uses_rt && mem_valid && (id_rt == mem_dst);
        stall        = id_valid && !flush && (rs_ex || rt_ex) && ex_load;
        bubble       = flush || stall || !id_valid;
    end

    // Forwarding select: EX-slot (newest) producer wins over MEM slot.
    always_comb begin
        fwd_a_next = FWD_RF;
        fwd_b_next = FWD_RF;
        if (!bubble) begin
            if (rs_ex && !ex_load) fwd_a_next = FWD_EXM;
            else if (rs_mem)       fwd_a_next = FWD_MWB;
            if (rt_ex && !ex_load) fwd_b_next = FWD_EXM;
            else if (rt_mem)       fwd_b_next = FWD_MWB;
        end
    end

    // Producer tracker: invalid slots carry dst 0 so *_dst reads 0 for "none".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_dst    <= '0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_dst   <= '0;
            wb_dst    <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
        end else begin
            wb_dst    <= mem_dst;
            mem_valid <= ex_valid;
            mem_dst   <= ex_dst;
            fwd_a     <= fwd_a_next;
            fwd_b     <= fwd_b_next;
            if (bubble || !id_dst_valid) begin
                ex_valid <= 1'b0;
                ex_dst   <= '0;
                ex_load  <= 1'b0;
            end else begin
                ex_valid <= 1'b1;
                ex_dst   <= id_dst;
                ex_load  <= id_memread;
            end
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed plus randomized checks of hazard_scoreboard
// against a pipeline-history reference model. Two instances share all inputs:
// one with the default 16-bit counter, one with a 4-bit counter for saturation.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rs, id_uses_rt, id_regdst, id_regwrite, id_memread, flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        dst_sel, stall, dst_sel4, stall4;
    logic [1:0]  fwd_a, fwd_b, fwd_a4, fwd_b4;
    logic [4:0]  ex_dst, mem_dst, wb_dst, ex_dst4, mem_dst4, wb_dst4;
    logic [15:0] stall_count;
    logic [3:0]  stall_count4;

    int errors = 0;
    int checks = 0;

    // Reference model: producer history, index 0 = EX, 1 = MEM, 2 = WB.
    int  h_dst [3];
    bit  h_load[3];
    int  exp_fwd_a, exp_fwd_b, exp_cnt;
    bit  last_stall;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .dst_sel(dst_sel), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst), .stall_count(stall_count)
    );

    hazard_scoreboard #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regdst(id_regdst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .dst_sel(dst_sel4), .stall(stall4), .fwd_a(fwd_a4), .fwd_b(fwd_b4),
        .ex_dst(ex_dst4), .mem_dst(mem_dst4), .wb_dst(wb_dst4), .stall_count(stall_count4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Select for one source: newest non-WB producer of that register wins.
    function automatic int fwd_for(input bit uses, input int r);
        if (!uses || r == 0) return 0;
        if (h_dst[0] == r)   return h_load[0] ? 0 : 2;
        if (h_dst[1] == r)   return 1;
        return 0;
    endfunction

    function automatic bit hits_ex_load(input bit urs, input int rs, input bit urt, input int rt);
        if (!h_load[0] || h_dst[0] == 0) return 1'b0;
        return (urs && rs == h_dst[0]) || (urt && rt == h_dst[0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            h_dst[i]  = 0;
            h_load[i] = 1'b0;
        end
        exp_fwd_a = 0;
        exp_fwd_b = 0;
        exp_cnt   = 0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".fwd_a"},   32'(fwd_a),   32'(exp_fwd_a));
        chk({tag, ".fwd_b"},   32'(fwd_b),   32'(exp_fwd_b));
        chk({tag, ".ex_dst"},  32'(ex_dst),  32'(h_dst[0]));
        chk({tag, ".mem_dst"}, 32'(mem_dst), 32'(h_dst[1]));
        chk({tag, ".wb_dst"},  32'(wb_dst),  32'(h_dst[2]));
        chk({tag, ".cnt16"},   32'(stall_count),  32'(exp_cnt > 65535 ? 65535 : exp_cnt));
        chk({tag, ".cnt4"},    32'(stall_count4), 32'(exp_cnt > 15 ? 15 : exp_cnt));
    endtask

    // One clock cycle with the given ID contents; called just after a rising edge.
    task automatic cyc(input string tag, input bit v, input int rs, input int rt, input int rd,
                       input bit urs, input bit urt, input bit regdst, input bit rw,
                       input bit mr, input bit fl);
        bit es;
        bit bub;
        int d;
        id_valid = v;      id_rs = 5'(rs);     id_rt = 5'(rt);     id_rd = 5'(rd);
        id_uses_rs = urs;  id_uses_rt = urt;   id_regdst = regdst;
        id_regwrite = rw;  id_memread = mr;    flush = fl;
        #1;
        es  = v && !fl && hits_ex_load(urs, rs, urt, rt);
        bub = fl || es || !v;
        d   = regdst ? rd : rt;
        chk({tag, ".stall"},   32'(stall),   32'(es));
        chk({tag, ".dst_sel"}, 32'(dst_sel), 32'(regdst));
        exp_fwd_a = bub ? 0 : fwd_for(urs, rs);
        exp_fwd_b = bub ? 0 : fwd_for(urt, rt);
        @(posedge clk);
        if (es) exp_cnt++;
        h_dst[2]  = h_dst[1];
        h_dst[1]  = h_dst[0];
        h_load[1] = h_load[0];
        if (bub || !rw || d == 0) begin
            h_dst[0]  = 0;
            h_load[0] = 1'b0;
        end else begin
            h_dst[0]  = d;
            h_load[0] = mr;
        end
        last_stall = es;
        #1;
        check_regs(tag);
    endtask

    // Issue an instruction, holding it in ID while the model predicts a stall.
    task automatic ins(input string tag, input int rs, input int rt, input int rd,
                       input bit urs, input bit urt, input bit regdst, input bit rw, input bit mr);
        int n = 0;
        cyc(tag, 1'b1, rs, rt, rd, urs, urt, regdst, rw, mr, 1'b0);
        while (last_stall && n < 4) begin
            cyc(tag, 1'b1, rs, rt, rd, urs, urt, regdst, rw, mr, 1'b0);
            n++;
        end
        if (n >= 4) begin
            checks++;
            errors++;
            $error("FAIL %s.stall_bound: observed=%0d expected=<4", tag, n);
        end
    endtask

    initial begin
        int cnt_before;
        int rs, rt, rd;
        bit v, urs, urt, rdst, rw, mr, fl;

        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_regdst = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        model_reset();
        last_stall = 1'b0;
        #12;
        chk("rst.stall", 32'(stall), 32'd0);
        check_regs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_regs("rel");

        // ALU chain: add $3 -> sub reads rs=3 -> consumer reads rt=3.
        ins("alu_add", 1, 2, 3, 1, 1, 1, 1, 0);
        ins("alu_sub", 3, 6, 4, 1, 1, 1, 1, 0);
        chk("alu_sub.fwd_a_exm", 32'(fwd_a), 32'd2);
        ins("alu_use", 9, 3, 8, 1, 1, 1, 1, 0);
        chk("alu_use.fwd_b_mwb", 32'(fwd_b), 32'd1);

        // Load-use: lw $5 then add reads rs=5.
        cnt_before = int'(stall_count);
        ins("lu_lw", 1, 5, 0, 1, 0, 0, 1, 1);
        ins("lu_add", 5, 2, 6, 1, 1, 1, 1, 0);
        chk("lu.count", 32'(stall_count), 32'(cnt_before + 1));
        chk("lu.fwd_a_mwb", 32'(fwd_a), 32'd1);

        // Register 0 never forwards.
        ins("r0_add", 1, 2, 0, 1, 1, 1, 1, 0);
        chk("r0.ex_dst", 32'(ex_dst), 32'd0);
        ins("r0_use", 0, 1, 9, 1, 1, 1, 1, 0);
        chk("r0.fwd_a", 32'(fwd_a), 32'd0);

        // Priority: newest producer of $7 wins.
        ins("pr_add1", 1, 2, 7, 1, 1, 1, 1, 0);
        ins("pr_add2", 3, 4, 7, 1, 1, 1, 1, 0);
        ins("pr_use", 7, 7, 10, 1, 1, 1, 1, 0);
        chk("pr.fwd_a", 32'(fwd_a), 32'd2);
        chk("pr.fwd_b", 32'(fwd_b), 32'd2);

        // Load into $7 then flush during the consumer's ID cycle.
        ins("fl_lw", 1, 7, 0, 1, 0, 0, 1, 1);
        cyc("fl_use", 1'b1, 7, 2, 11, 1, 1, 1, 1, 0, 1'b1);
        chk("fl.ex_dst", 32'(ex_dst), 32'd0);

        // Mid-stream reset with a load in EX and a dependent in ID.
        ins("mr_lw", 1, 12, 0, 1, 0, 0, 1, 1);
        id_valid = 1; id_rs = 5'd12; id_uses_rs = 1; id_uses_rt = 0; flush = 0;
        #1;
        chk("mr.stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mr.stall", 32'(stall), 32'd0);
        check_regs("mr");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ins("mr_after", 12, 0, 13, 1, 0, 1, 1, 0);
        chk("mr_after.fwd_a", 32'(fwd_a), 32'd0);

        // Saturation: 20 load-use pairs, 4-bit counter stops at 15.
        for (int i = 0; i < 20; i++) begin
            ins("sat_lw", 1, 5, 0, 1, 0, 0, 1, 1);
            ins("sat_add", 5, 2, 6, 1, 1, 1, 1, 0);
        end
        chk("sat.cnt4", 32'(stall_count4), 32'd15);
        chk("sat.cnt16", 32'(stall_count), 32'(exp_cnt));

        // Randomized traffic over a small register set to provoke hazards.
        v = 1; rs = 0; rt = 0; rd = 0; urs = 0; urt = 0; rdst = 0; rw = 0; mr = 0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                v    = ($urandom_range(9) != 0);
                rs   = int'($urandom_range(7));
                rt   = int'($urandom_range(7));
                rd   = int'($urandom_range(7));
                urs  = 1'($urandom);
                urt  = 1'($urandom);
                rdst = 1'($urandom);
                rw   = ($urandom_range(3) != 0);
                mr   = ($urandom_range(2) == 0);
            end
            fl = ($urandom_range(9) == 0);
            cyc("rnd", v, rs, rt, rd, urs, urt, rdst, rw, mr, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Load-use hazard detector and forwarding scheduler for the 5-stage MIPS pipeline. Sits beside the ID stage and owns the `Select` of the 5-bit destination-register mux: it picks rd or rt per instruction, tracks the selected destination through EX/MEM/WB, stalls ID on load-use conflicts, and issues registered forwarding selects for the instruction entering EX. It also keeps a saturating stall counter for performance debug.

## Interface
- `CNT_W`, default 16: width of the stall counter.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `id_rs` input 5: source register rs of the ID instruction.
- `id_rt` input 5: rt field; source and/or destination.
- `id_rd` input 5: rd field.
- `id_uses_rs`, `id_uses_rt` input 1 each: the instruction reads rs / rt.
- `id_regdst` input 1: 1 selects rd as destination, 0 selects rt.
- `id_regwrite` input 1: the instruction writes the register file.
- `id_memread` input 1: the instruction is a load.
- `flush` input 1: branch taken; kill the ID instruction this cycle.
- `dst_sel` output 1: drives the destination mux `Select`.
- `stall` output 1: freeze PC and IF/ID; insert a bubble into ID/EX.
- `fwd_a`, `fwd_b` output 2 each: forwarding selects for ALU operands A (rs) and B (rt) in EX. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- `ex_dst`, `mem_dst`, `wb_dst` output 5 each: tracked destinations; 0 = none.
- `stall_count` output CNT_W: number of stall cycles, saturating.

## Operation
- `dst_sel` = `id_regdst` (combinational pass-through). The selected destination is `d` = `id_regdst` ? `id_rd` : `id_rt`.
- Tracker: three slots, EX, MEM and WB. Each slot holds {valid, dst[4:0], load}. A slot is valid only if regwrite was set and `d` != 0. Register 0 never matches.
- Each clock: WB <= MEM and MEM <= EX.
- EX <= bubble (all zero) if `flush`, `stall` or !`id_valid`.
- Otherwise EX <= {`id_regwrite` && `d`!=0, `d`, `id_memread`}.
- Match rules (combinational): a source matches a slot when the use bit is set, the slot is valid, and the register numbers are equal.
- Stall (combinational): `stall` = `id_valid` && !`flush` && (the rs or rt source matches the EX slot) && EX.load.
- Forwarding selects are computed in ID and registered, so they are valid during the instruction's EX cycle:
  - Source matches the EX slot and that slot is not a load -> 10. The producer will be in EX/MEM next cycle.
  - Otherwise, source matches the MEM slot -> 01. The producer will be in MEM/WB next cycle.
  - Otherwise -> 00.
  - The EX slot has priority over the MEM slot, so the newest producer wins.
  - When a bubble is loaded into EX (flush, stall or invalid), both `fwd_a` and `fwd_b` register to 00.
- A producer in the WB slot is never forwarded. The register file writes in the first half-cycle and reads in the second.
- `stall_count` increments by 1 on each clock edge where `stall` = 1. It holds at all-ones.
- `flush` and a stall condition in the same cycle: `flush` wins, `stall` = 0, and a bubble enters EX.

## Timing
- Reset (async, `rst_n` low): all slots are invalid with dst 0. `fwd_a`, `fwd_b`, `ex_dst`, `mem_dst` and `wb_dst` are 0, and `stall_count` is 0.
- During reset, `stall` = 0 because the EX slot is invalid. `dst_sel` follows `id_regdst`.
- Reset asserted mid-operation discards all tracked producers immediately. There is no pending stall after release.
- Load-use costs exactly 1 stall cycle. The cycle after the stall, the load is in the MEM slot and the consumer gets `fwd` = 01.
- `stall` and `dst_sel` have zero latency (combinational from inputs and state).
- `fwd_*` and `*_dst` have 1-cycle latency (registered).
- Back-to-back producers to the same register: the newer one (EX slot) is the one forwarded.

## Test plan
- Reset, then release: all outputs 0 and `stall` = 0. Assert `rst_n` low mid-stream with a load in EX: `stall` drops at once, and `ex_dst`/`mem_dst`/`wb_dst` read 0.
- ALU chain: `add $3` (regdst = 1, rd = 3), then `sub` reading rs = 3 -> no stall, and `fwd_a` = 10 in the sub's EX cycle. A third instruction reading rt = 3 two slots later -> `fwd_b` = 01.
- Load-use: `lw $5` (regdst = 0, rt = 5, memread), then `add` reading rs = 5 -> `stall` = 1 for exactly 1 cycle, `stall_count` = 1. On the add's EX cycle, `fwd_a` = 01.
- Register 0: `add $0`, then a consumer reading rs = 0 -> `fwd_a` = 00, no stall, and `ex_dst` = 0.
- Priority: `add $7`, `add $7`, then a consumer reading $7 -> `fwd` = 10, not 01. A load into $7 followed by `flush` in the consumer's ID cycle -> `stall` = 0 and a bubble enters EX.
- Saturation: with `CNT_W` = 4, force 20 stall cycles -> `stall_count` stops at 15.
